// File: rtl/prbs7_chain_checker_if.sv
// Bit-stream bus between the flip-flop test chain and the PRBS7 checker.
// Optional macro PRBS_INV_EN adds the inv_pol polarity configuration input.
interface prbs7_chain_checker_if #(
  parameter int ERR_W = 16
);
  logic             en;
  logic             din;
  logic             clr_err;
`ifdef PRBS_INV_EN
  logic             inv_pol;
`endif
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;

`ifdef PRBS_INV_EN
  modport master (output en, output din, output clr_err, output inv_pol,
                  input locked, input err_pulse, input err_cnt);
  modport slave  (input en, input din, input clr_err, input inv_pol,
                  output locked, output err_pulse, output err_cnt);
`else
  modport master (output en, output din, output clr_err,
                  input locked, input err_pulse, input err_cnt);
  modport slave  (input en, input din, input clr_err,
                  output locked, output err_pulse, output err_cnt);
`endif
endinterface

// File: rtl/prbs7_chain_checker.sv
// Self-synchronising PRBS7 (x^7+x^6+1) checker for the flip-flop test chain.
// Fills a 7-bit history, hunts for LOCK_CNT clean bits, then counts errors
// with a saturating counter and drops lock after LOSS_THRESH bad bits.
// Optional macro PRBS_INV_EN: adds inv_pol, data is checked as din ^ inv_pol.
module prbs7_chain_checker #(
  parameter int ERR_W       = 16,
  parameter int LOCK_CNT    = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  prbs7_chain_checker_if.slave   bus
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {FILL, HUNT, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [6:0]        sr_q, sr_d;
  logic [2:0]        fill_q, fill_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [GOOD_W-1:0] clean_q, clean_d;
  logic [7:0]        bad_q, bad_d;
  logic              locked_q, locked_d;
  logic              err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic              d_bit;
  logic              exp_bit;
  logic              mis;
  logic              counted;
  logic [GOOD_W:0]   good_inc;
  logic [GOOD_W:0]   clean_inc;
  logic [8:0]        bad_inc;
  logic [ERR_W-1:0]  err_base;

  // Effective data bit, predicted bit and mismatch decision for this sample
  always_comb begin
`ifdef PRBS_INV_EN
    d_bit = bus.din ^ bus.inv_pol;
`else
    d_bit = bus.din;
`endif
    exp_bit   = sr_q[6] ^ sr_q[5];
    mis       = (d_bit ^ exp_bit) | ((sr_q == 7'd0) & ~d_bit);
    good_inc  = {1'b0, good_q} + 1'b1;
    clean_inc = {1'b0, clean_q} + 1'b1;
    bad_inc   = {1'b0, bad_q} + 1'b1;
  end

  // Next-state logic: fill, hunt and locked error tracking; all gated by en
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    good_d      = good_q;
    clean_d     = clean_q;
    bad_d       = bad_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    counted     = 1'b0;
    if (bus.en) begin
      sr_d = {sr_q[5:0], d_bit};
      case (state_q)
        FILL: begin
          fill_d = fill_q + 3'd1;
          if (fill_q == 3'd6) begin
            state_d = HUNT;
          end
        end
        HUNT: begin
          if (mis) begin
            good_d = '0;
          end else if (good_inc == (GOOD_W + 1)'(LOCK_CNT)) begin
            good_d   = '0;
            state_d  = LOCKED;
            locked_d = 1'b1;
          end else begin
            good_d = good_inc[GOOD_W-1:0];
          end
        end
        LOCKED: begin
          if (mis) begin
            err_pulse_d = 1'b1;
            counted     = 1'b1;
            clean_d     = '0;
            if (bad_inc == 9'(LOSS_THRESH)) begin
              // Lock lost: history is kept, so hunting resumes without a refill
              bad_d    = '0;
              good_d   = '0;
              state_d  = HUNT;
              locked_d = 1'b0;
            end else begin
              bad_d = bad_inc[7:0];
            end
          end else if (clean_inc == (GOOD_W + 1)'(LOCK_CNT)) begin
            bad_d   = '0;
            clean_d = '0;
          end else begin
            clean_d = clean_inc[GOOD_W-1:0];
          end
        end
        default: begin
          state_d  = FILL;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // Saturating error counter; a coincident clear is applied before the increment
  always_comb begin
    err_base  = bus.clr_err ? '0 : err_cnt_q;
    err_cnt_d = err_base;
    if (counted && (err_base != {ERR_W{1'b1}})) begin
      err_cnt_d = err_base + 1'b1;
    end
  end

  // State and output registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      sr_q        <= '0;
      fill_q      <= '0;
      good_q      <= '0;
      clean_q     <= '0;
      bad_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      good_q      <= good_d;
      clean_q     <= clean_d;
      bad_q       <= bad_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: doc/prbs7_chain_checker.md
Name: prbs7_chain_checker

Overview:
- Downstream consumer of the flip-flop test chain: samples the chain's serial output and checks it against a self-synchronising PRBS7 (x^7+x^6+1).
- Acquires lock, then counts bit errors with a saturating counter and flags loss of lock.
- Gives a pass/fail and error-rate readout for the chain under test without needing the transmit seed.

Parameters:
- ERR_W, 16: width of the saturating error counter.
- LOCK_CNT, 16: consecutive correct bits needed to lock. The same count of clean bits while locked clears the loss counter.
- LOSS_THRESH, 4: bad bits, without an intervening clean run of LOCK_CNT, that drop lock. Range 1..255.

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- rst, input, 1: asynchronous active-high reset.
- en, input, 1: bit-valid strobe; din is sampled only when en=1.
- din, input, 1: serial data from the test chain output.
- clr_err, input, 1: synchronous clear of err_cnt.
- locked, output, 1: checker is in the LOCKED state.
- err_pulse, output, 1: one-cycle pulse for each bit error counted.
- err_cnt, output, ERR_W: saturating count of errors seen while LOCKED.

Behaviour:
- Reset (async, active-high): the following clear immediately, without a clock edge:
  - sr (7-bit history) = 0, fill = 0, good_cnt = 0, bad_cnt = 0, clean_cnt = 0
  - state = FILL, locked = 0, err_pulse = 0, err_cnt = 0
- Per sample (en=1), where d = effective data bit:
  - exp = sr[6]^sr[5]
  - mis = (d^exp) | (sr==0 & d==0)
  - The zero guard rejects all-zero streams; PRBS7 never has 8 zeros in a row.
  - sr <= {sr[5:0], d} on every sample, in every state.
- en=0: no register changes except err_pulse <= 0.
- FILL:
  - Increment fill and ignore mis.
  - When the 7th bit is shifted in, go to HUNT.
- HUNT:
  - mis -> good_cnt <= 0.
  - Else good_cnt++.
  - When good_cnt reaches LOCK_CNT, go to LOCKED. locked=1 from the cycle after the LOCK_CNT-th good sample.
  - Lock latency from reset with continuous en: 7+LOCK_CNT samples.
- LOCKED, on mis:
  - err_pulse <= 1 for that single cycle.
  - err_cnt++, saturating at all-ones.
  - bad_cnt++ and clean_cnt <= 0.
  - If bad_cnt+1 == LOSS_THRESH: go to HUNT, locked <= 0, good_cnt <= 0. sr is kept, so there is no refill.
- LOCKED, on a correct bit:
  - clean_cnt++.
  - When clean_cnt reaches LOCK_CNT: bad_cnt <= 0 and clean_cnt <= 0.
- Errors are counted only in LOCKED. A mis in FILL or HUNT never touches err_cnt or err_pulse.
- A single flipped bit gives exactly 3 mismatches: at its own sample, and 6 and 7 samples later.
- clr_err:
  - Sets err_cnt to 0 on the next edge.
  - If it coincides with a counted error, the clear applies first and err_cnt becomes 1.
  - Clearing has no effect on state, bad_cnt or locked.
- Saturation: err_cnt holds at 2^ERR_W-1; err_pulse still fires.
- Reset asserted mid-operation: return to the reset state asynchronously; lock is reacquired from FILL.

Optional Feature:
- Macro PRBS_INV_EN.
- Defined:
  - Adds input port inv_pol (1 bit).
  - Effective data d = din ^ inv_pol. This supports chains with an odd number of inverting stages.
  - The zero guard and all checks operate on d.
  - inv_pol is a static configuration input; changing it while LOCKED produces errors like any other data corruption.
- Undefined: no inv_pol port, and d = din.

Test Plan:
- Clean PRBS7 from seed 7'h7F, en=1 continuously, LOCK_CNT=16 -> locked rises the cycle after sample 23. err_cnt=0 and err_pulse never asserts over 254 further samples.
- Locked, flip one bit at sample k -> err_pulse at samples k, k+6, k+7. err_cnt=3, locked stays 1 (LOSS_THRESH=4).
- Locked, din stuck at 0 -> err_cnt increments. locked falls after the 4th counted error and never re-locks while din stays 0. Stuck-0 from reset -> locked never asserts.
- ERR_W=2, three single-bit flips spaced 40 samples apart -> 9 err_pulses, err_cnt saturates at 3, locked stays 1. clr_err coincident with the next error -> err_cnt=1.
- Random en gaps (en=0 for 0-3 cycles between samples) on the clean stream -> same lock sample count and err_cnt as the continuous case. err_pulse never asserts during gaps.
- rst asserted mid-LOCKED between clock edges -> locked, err_cnt, err_pulse are 0 before the next edge. After release, re-lock takes exactly 23 samples.
